// File: rtl/versatile_io_pkg.sv
// Shared definitions for the versatile_io Wishbone-to-byte-channel mux:
// FSM state encoding, default address-map/timeout constants and the
// byte/word packing helpers.
package versatile_io_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam int DEF_MAP_HI = 15;
  localparam int DEF_MAP_LO = 12;
  localparam int DEF_TO_CYC = 255;

  // Collapse a 32-bit word to one byte: OR of every byte lane whose select is set.
  function automatic logic [7:0] tobyte(input logic [31:0] word, input logic [3:0] sel);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) b = b | word[i*8 +: 8];
    end
    return b;
  endfunction

  // Replicate a byte across all four lanes of a Wishbone word.
  function automatic logic [31:0] toword(input logic [7:0] b);
    return {4{b}};
  endfunction

endpackage

// File: rtl/versatile_io_timeout.sv
// Saturating BUSY-cycle counter. Held at zero while clear is high, counts
// up while enable is high, and flags tc once the count equals LIMIT.
// Only instantiated when VIO_TIMEOUT_EN is defined.
module versatile_io_timeout
  import versatile_io_pkg::*;
#(
  parameter int LIMIT = DEF_TO_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count_reg;

  assign tc = enable && (count_reg == CNT_W'(LIMIT));

  // Count BUSY cycles; stop at the limit so the flag cannot wrap away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !tc) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/versatile_io_wbs_mux.sv
// Wishbone slave that routes single byte accesses to one of NR_CH byte-wide
// peripheral channels selected by an address-field decode.
// Optional feature: define VIO_TIMEOUT_EN to abort a channel that does not
// acknowledge within TO_CYC cycles (reported as a Wishbone error).
module versatile_io_wbs_mux
  import versatile_io_pkg::*;
#(
  parameter int                   NR_CH   = 4,
  parameter int                   MAP_HI  = DEF_MAP_HI,
  parameter int                   MAP_LO  = DEF_MAP_LO,
  parameter logic [NR_CH*32-1:0]  CH_BASE = {32'h4000, 32'h3000, 32'h2000, 32'h1000},
  parameter int                   ADR_W   = 3,
  parameter int                   TO_CYC  = DEF_TO_CYC
) (
  input  logic                 wbs_clk,
  input  logic                 wbs_rst,
  input  logic [31:0]          wbs_dat_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic                 wbs_we_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_cyc_i,
  output logic [31:0]          wbs_dat_o,
  output logic                 wbs_ack_o,
  output logic                 wbs_err_o,
  output logic                 wbs_stall_o,
  output logic [7:0]           ch_dat_o,
  output logic [ADR_W-1:0]     ch_adr_o,
  output logic                 ch_we_o,
  output logic                 ch_stb_o,
  output logic [NR_CH-1:0]     ch_cyc_o,
  input  logic [NR_CH*8-1:0]   ch_dat_i,
  input  logic [NR_CH-1:0]     ch_ack_i
);

  localparam int IDX_W = (NR_CH > 1) ? $clog2(NR_CH) : 1;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, hit_idx;
  logic [NR_CH-1:0] hit_vec;
  logic [7:0]       ch_byte [NR_CH];
  logic [ADR_W-1:0] adr_reg;
  logic             we_reg;
  logic [7:0]       wbyte_reg, rbyte_reg;
  logic             req, good_req, accept, sel_ack, abort, timeout;
  logic             unused_adr;

  // Only the decoded field and the low channel-address bits matter.
  assign unused_adr = ^wbs_adr_i;

  assign req      = wbs_cyc_i & wbs_stb_i;
  assign good_req = (|hit_vec) && (wbs_sel_i != 4'b0000);
  assign accept   = (state_reg == IDLE) && req && good_req;
  assign sel_ack  = ch_ack_i[idx_reg];
  assign abort    = !wbs_cyc_i;

  genvar gi;
  generate
    for (gi = 0; gi < NR_CH; gi++) begin : g_chan
      assign hit_vec[gi] = (wbs_adr_i[MAP_HI:MAP_LO] == CH_BASE[gi*32+MAP_HI : gi*32+MAP_LO]);
      assign ch_byte[gi] = ch_dat_i[gi*8 +: 8];
    end
  endgenerate

  // Priority encoder: scanning downwards leaves the lowest hitting index.
  always_comb begin
    hit_idx = '0;
    for (int i = NR_CH - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_idx = IDX_W'(i);
    end
  end

`ifdef VIO_TIMEOUT_EN
  versatile_io_timeout #(
    .LIMIT(TO_CYC)
  ) u_timeout (
    .clk   (wbs_clk),
    .rst_n (wbs_rst),
    .clear (state_reg != BUSY),
    .enable(state_reg == BUSY),
    .tc    (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge wbs_clk or negedge wbs_rst) begin
    if (!wbs_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and Wishbone/channel handshake outputs. A master abort wins
  // over a simultaneous channel ack, which in turn wins over a timeout.
  always_comb begin
    state_next  = state_reg;
    wbs_ack_o   = 1'b0;
    wbs_err_o   = 1'b0;
    wbs_dat_o   = 32'h0;
    wbs_stall_o = (state_reg != IDLE);
    ch_stb_o    = 1'b0;
    ch_cyc_o    = '0;
    unique case (state_reg)
      IDLE: begin
        if (req) state_next = good_req ? BUSY : ERR;
      end
      BUSY: begin
        ch_stb_o          = 1'b1;
        ch_cyc_o[idx_reg] = 1'b1;
        if (abort)        state_next = IDLE;
        else if (sel_ack) state_next = RESP;
        else if (timeout) state_next = ERR;
      end
      RESP: begin
        wbs_ack_o  = 1'b1;
        wbs_dat_o  = toword(rbyte_reg);
        state_next = IDLE;
      end
      ERR: begin
        wbs_err_o  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch on acceptance and read-byte capture on the channel ack.
  // Writes return an all-zero data word.
  always_ff @(posedge wbs_clk or negedge wbs_rst) begin
    if (!wbs_rst) begin
      idx_reg   <= '0;
      adr_reg   <= '0;
      we_reg    <= 1'b0;
      wbyte_reg <= 8'h00;
      rbyte_reg <= 8'h00;
    end else begin
      if (accept) begin
        idx_reg   <= hit_idx;
        adr_reg   <= wbs_adr_i[ADR_W-1:0];
        we_reg    <= wbs_we_i;
        wbyte_reg <= tobyte(wbs_dat_i, wbs_sel_i);
      end
      if ((state_reg == BUSY) && !abort && sel_ack) begin
        rbyte_reg <= we_reg ? 8'h00 : ch_byte[idx_reg];
      end
    end
  end

  assign ch_dat_o = wbyte_reg;
  assign ch_adr_o = adr_reg;
  assign ch_we_o  = we_reg;

endmodule

// File: tb/tb_versatile_io_wbs_mux.sv
// Self-checking bench for versatile_io_wbs_mux (NR_CH=2, bases 0x1000/0x2000).
// Transactions are predicted from the address map and lane rules directly.
module tb_versatile_io_wbs_mux;

  localparam int NR_CH  = 2;
  localparam int ADR_W  = 3;
  localparam int TO_CYC = 8;

  logic [31:0] base_tab [NR_CH] = '{32'h1000, 32'h2000};

  logic               wbs_clk = 1'b0;
  logic               wbs_rst = 1'b0;
  logic [31:0]        wbs_dat_i = '0, wbs_adr_i = '0;
  logic [3:0]         wbs_sel_i = '0;
  logic               wbs_we_i = 1'b0, wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0;
  logic [31:0]        wbs_dat_o;
  logic               wbs_ack_o, wbs_err_o, wbs_stall_o;
  logic [7:0]         ch_dat_o;
  logic [ADR_W-1:0]   ch_adr_o;
  logic               ch_we_o, ch_stb_o;
  logic [NR_CH-1:0]   ch_cyc_o;
  logic [NR_CH*8-1:0] ch_dat_i = '0;
  logic [NR_CH-1:0]   ch_ack_i = '0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 wbs_clk = ~wbs_clk;

  versatile_io_wbs_mux #(
    .NR_CH  (NR_CH),
    .MAP_HI (15),
    .MAP_LO (12),
    .CH_BASE({32'h2000, 32'h1000}),
    .ADR_W  (ADR_W),
    .TO_CYC (TO_CYC)
  ) dut (
    .wbs_clk    (wbs_clk),
    .wbs_rst    (wbs_rst),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_dat_o  (wbs_dat_o),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_err_o  (wbs_err_o),
    .wbs_stall_o(wbs_stall_o),
    .ch_dat_o   (ch_dat_o),
    .ch_adr_o   (ch_adr_o),
    .ch_we_o    (ch_we_o),
    .ch_stb_o   (ch_stb_o),
    .ch_cyc_o   (ch_cyc_o),
    .ch_dat_i   (ch_dat_i),
    .ch_ack_i   (ch_ack_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wbs_clk);
    #1;
  endtask

  // Reference: first channel whose base matches the address nibble, else -1.
  function automatic int ref_chan(input logic [31:0] a);
    logic [31:0] b;
    for (int k = 0; k < NR_CH; k++) begin
      b = base_tab[k];
      if (a[15:12] == b[15:12]) return k;
    end
    return -1;
  endfunction

  // Reference: OR of the selected byte lanes.
  function automatic logic [7:0] ref_byte(input logic [31:0] d, input logic [3:0] s);
    logic [7:0] r;
    r = 8'h00;
    for (int l = 0; l < 4; l++) if (s[l]) r = r | d[l*8 +: 8];
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_dat"}, wbs_dat_o, 32'h0);
    check({tag, "_ack"}, 32'(wbs_ack_o), 32'h0);
    check({tag, "_err"}, 32'(wbs_err_o), 32'h0);
    check({tag, "_stall"}, 32'(wbs_stall_o), 32'h0);
    check({tag, "_cyc"}, 32'(ch_cyc_o), 32'h0);
    check({tag, "_stb"}, 32'(ch_stb_o), 32'h0);
    check({tag, "_we"}, 32'(ch_we_o), 32'h0);
    check({tag, "_adr"}, 32'(ch_adr_o), 32'h0);
    check({tag, "_chdat"}, 32'(ch_dat_o), 32'h0);
  endtask

  // Issue one request; accepted ones get a channel ack after dly extra BUSY cycles.
  task automatic run_txn(input logic [31:0] a, input logic [3:0] s, input logic w,
                         input logic [31:0] d, input int dly, input logic [7:0] rdata);
    int               ch;
    logic [7:0]       wb;
    logic [NR_CH-1:0] mask;
    ch = ref_chan(a);
    wb = ref_byte(d, s);
    check("idle_stall", 32'(wbs_stall_o), 32'h0);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = a; wbs_sel_i = s; wbs_we_i = w; wbs_dat_i = d;
    tick();
    // Scramble the bus after acceptance: the channel side must hold latched values.
    wbs_stb_i = 1'b0; wbs_adr_i = $urandom; wbs_sel_i = 4'($urandom); wbs_we_i = ~w; wbs_dat_i = $urandom;
    if (ch < 0 || s == 4'b0000) begin
      check("err_pulse", 32'(wbs_err_o), 32'h1);
      check("err_noack", 32'(wbs_ack_o), 32'h0);
      check("err_nocyc", 32'(ch_cyc_o), 32'h0);
      check("err_nostb", 32'(ch_stb_o), 32'h0);
      wbs_cyc_i = 1'b0;
      tick();
      check("err_once", 32'(wbs_err_o), 32'h0);
      check("err_back_idle", 32'(wbs_stall_o), 32'h0);
      $display("txn adr=%h sel=%b we=%b -> error", a, s, w);
    end else begin
      mask = '0;
      mask[ch] = 1'b1;
      for (int c = 0; c <= dly; c++) begin
        check("busy_cyc", 32'(ch_cyc_o), 32'(mask));
        check("busy_stb", 32'(ch_stb_o), 32'h1);
        check("busy_adr", 32'(ch_adr_o), 32'(a[ADR_W-1:0]));
        check("busy_wbyte", 32'(ch_dat_o), 32'(wb));
        check("busy_we", 32'(ch_we_o), 32'(w));
        check("busy_stall", 32'(wbs_stall_o), 32'h1);
        check("busy_noack", 32'(wbs_ack_o), 32'h0);
        check("busy_noerr", 32'(wbs_err_o), 32'h0);
        ch_dat_i = NR_CH*8'($urandom);
        ch_ack_i = NR_CH'($urandom) & ~mask;
        if (c == dly) begin
          ch_ack_i[ch] = 1'b1;
          ch_dat_i[ch*8 +: 8] = w ? 8'h00 : rdata;
        end
        tick();
      end
      ch_ack_i = '0;
      check("resp_ack", 32'(wbs_ack_o), 32'h1);
      check("resp_dat", wbs_dat_o, w ? 32'h0 : {4{rdata}});
      check("resp_noerr", 32'(wbs_err_o), 32'h0);
      check("resp_cyc_drop", 32'(ch_cyc_o), 32'h0);
      check("resp_stb_drop", 32'(ch_stb_o), 32'h0);
      wbs_cyc_i = 1'b0;
      tick();
      check("post_ack", 32'(wbs_ack_o), 32'h0);
      check("post_dat", wbs_dat_o, 32'h0);
      check("post_stall", 32'(wbs_stall_o), 32'h0);
      $display("txn adr=%h sel=%b we=%b -> ch%0d ack after %0d cycles", a, s, w, ch, dly + 1);
    end
  endtask

  task automatic start_req(input logic [31:0] a, input logic [3:0] s, input logic w, input logic [31:0] d);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = a; wbs_sel_i = s; wbs_we_i = w; wbs_dat_i = d;
    tick();
    wbs_stb_i = 1'b0;
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    int          kind;
    bit          seen;

    // Reset state.
    repeat (3) @(posedge wbs_clk);
    #1;
    check_all_zero("reset");
    @(negedge wbs_clk);
    wbs_rst = 1'b1;
    tick();

    // Directed: write with lane 2, read returning 0x5A, two error cases.
    run_txn(32'h0000_1003, 4'b0100, 1'b1, 32'h00AB_0000, 1, 8'h00);
    run_txn(32'h0000_2001, 4'b0001, 1'b0, 32'h0, 0, 8'h5A);
    run_txn(32'h0000_7000, 4'b1111, 1'b0, 32'h0, 0, 8'h00);
    run_txn(32'h0000_1000, 4'b0000, 1'b1, 32'h1234_5678, 0, 8'h00);

    // Randomized mix of hits on both channels, misses and empty selects.
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 5);
      a = $urandom;
      s = 4'($urandom_range(1, 15));
      d = $urandom;
      case (kind)
        0, 1: a[15:12] = 4'h1;
        2, 3: a[15:12] = 4'h2;
        4: begin
          a[15:12] = 4'($urandom_range(3, 15));
          if ($urandom_range(0, 1) == 1) a[15:12] = 4'h0;
        end
        default: begin
          a[15:12] = 4'($urandom_range(1, 2));
          s = 4'b0000;
        end
      endcase
      run_txn(a, s, 1'($urandom), d, $urandom_range(0, 3), 8'($urandom));
    end

    // Master abort during BUSY; a late ack must be ignored.
    start_req(32'h0000_1002, 4'b0001, 1'b0, 32'h0);
    check("abort_busy_cyc", 32'(ch_cyc_o), 32'h1);
    wbs_cyc_i = 1'b0;
    tick();
    check("abort_cyc_drop", 32'(ch_cyc_o), 32'h0);
    check("abort_stb_drop", 32'(ch_stb_o), 32'h0);
    check("abort_idle", 32'(wbs_stall_o), 32'h0);
    check("abort_noack", 32'(wbs_ack_o), 32'h0);
    check("abort_noerr", 32'(wbs_err_o), 32'h0);
    ch_ack_i = 2'b01; ch_dat_i = 16'h77EE;
    tick();
    check("abort_late_ack", 32'(wbs_ack_o), 32'h0);
    check("abort_late_err", 32'(wbs_err_o), 32'h0);
    ch_ack_i = '0;
    tick();
    check("abort_late_ack2", 32'(wbs_ack_o), 32'h0);
    $display("txn adr=00001002 abort by master");

    // Unacknowledged channel: timeout error, or indefinite stall without it.
    start_req(32'h0000_2004, 4'b0010, 1'b1, 32'h0000_3C00);
`ifdef VIO_TIMEOUT_EN
    seen = 1'b0;
    for (int c = 0; c < TO_CYC + 6 && !seen; c++) begin
      if (wbs_err_o) seen = 1'b1;
      else tick();
    end
    check("timeout_err_seen", 32'(seen), 32'h1);
    check("timeout_cyc_drop", 32'(ch_cyc_o), 32'h0);
    check("timeout_noack", 32'(wbs_ack_o), 32'h0);
    tick();
    check("timeout_err_once", 32'(wbs_err_o), 32'h0);
    wbs_cyc_i = 1'b0;
    $display("txn adr=00002004 no channel ack -> timeout error");
`else
    seen = 1'b0;
    for (int c = 0; c < 3 * TO_CYC; c++) begin
      if (!wbs_stall_o || ch_cyc_o != 2'b10 || wbs_err_o || wbs_ack_o) seen = 1'b1;
      tick();
    end
    check("hang_stays_busy", 32'(seen), 32'h0);
    check("hang_stall", 32'(wbs_stall_o), 32'h1);
    wbs_cyc_i = 1'b0;
    tick();
    check("hang_abort_idle", 32'(wbs_stall_o), 32'h0);
    $display("txn adr=00002004 no channel ack -> waits until master abort");
`endif
    tick();

    // Asynchronous reset during BUSY.
    start_req(32'h0000_1005, 4'b1000, 1'b1, 32'hCD00_0000);
    check("rst_pre_cyc", 32'(ch_cyc_o), 32'h1);
    check("rst_pre_dat", 32'(ch_dat_o), 32'hCD);
    #2 wbs_rst = 1'b0;
    #1 check_all_zero("rst_mid");
    ch_ack_i = 2'b01;
    @(negedge wbs_clk);
    wbs_rst = 1'b1;
    tick();
    check("rst_after_ack", 32'(wbs_ack_o), 32'h0);
    check("rst_after_err", 32'(wbs_err_o), 32'h0);
    ch_ack_i = '0;
    wbs_cyc_i = 1'b0;
    tick();
    check("rst_after_ack2", 32'(wbs_ack_o), 32'h0);
    check("rst_after_err2", 32'(wbs_err_o), 32'h0);
    $display("txn adr=00001005 aborted by reset");
    run_txn(32'h0000_2006, 4'b0011, 1'b0, 32'h0, 2, 8'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Watchdog so the run can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/versatile_io_wbs_mux.md
VERSATILE_IO_WBS_MUX -- requirements
Module: versatile_io_wbs_mux

Interface
REQ-001 Parameter NR_CH, default 4, meaning number of byte-wide peripheral channels (1..8).
REQ-002 Parameter MAP_HI, default 15, meaning MSB of the decoded address field.
REQ-003 Parameter MAP_LO, default 12, meaning LSB of the decoded address field.
REQ-004 Parameter CH_BASE, default {32'h4000,32'h3000,32'h2000,32'h1000}, meaning packed per-channel base addresses, with channel 0 in bits [31:0].
REQ-005 Parameter ADR_W, default 3, meaning channel address width.
REQ-006 Parameter TO_CYC, default 255, meaning timeout limit in clock cycles.
REQ-007 Clock and reset: one clock, wbs_clk; reset is asynchronous and active-low, port wbs_rst.
REQ-008 wbs_clk  in  1  clock.
REQ-009 wbs_rst  in  1  async active-low reset.
REQ-010 Wishbone slave inputs: wbs_dat_i in 32; wbs_adr_i in 32; wbs_sel_i in 4; wbs_we_i, wbs_stb_i, wbs_cyc_i in 1 each.
REQ-011 Wishbone slave outputs: wbs_dat_o out 32; wbs_ack_o, wbs_err_o, wbs_stall_o out 1 each.
REQ-012 Channel outputs: ch_dat_o out 8 (shared write byte); ch_adr_o out ADR_W; ch_we_o out 1; ch_stb_o out 1; ch_cyc_o out NR_CH (one-hot).
REQ-013 Channel inputs: ch_dat_i in NR_CH*8 (read bytes); ch_ack_i in NR_CH.

Function
REQ-014 FSM states: IDLE, BUSY, RESP, ERR.
REQ-015 Hit decode: channel k hits when wbs_adr_i[MAP_HI:MAP_LO] equals CH_BASE k [MAP_HI:MAP_LO]; when several channels hit, the lowest index wins.
REQ-016 Write byte: byte = OR over lanes i of (sel[i] AND the data byte of lane i).
REQ-017 IDLE with cyc&stb and a hit and sel!=0: latch channel index, adr[ADR_W-1:0], we and the write byte, then go to BUSY; ch_cyc_o[k] and ch_stb_o are asserted from the next cycle.
REQ-018 IDLE with cyc&stb and (no hit or sel==0): go to ERR; wbs_err_o is high for exactly one cycle, the cycle after the request.
REQ-019 BUSY with ch_ack_i[k]=1: capture ch_dat_i byte k, drop ch_cyc_o/ch_stb_o, then go to RESP.
REQ-020 Acks from non-selected channels are ignored.
REQ-021 RESP: wbs_ack_o is high for one cycle; wbs_dat_o = captured byte replicated 4x; then go to IDLE.
REQ-022 wbs_dat_o is 0 whenever wbs_ack_o=0.
REQ-023 Latency: request accepted in cycle N, channel ack in cycle M (M>=N+1), wbs_ack_o in cycle M+1.
REQ-024 wbs_stall_o = (state != IDLE); at most one transaction is outstanding.
REQ-025 Master abort: wbs_cyc_i=0 while in BUSY drops the channel strobes in the next cycle and returns to IDLE, with no ack and no err.
REQ-026 wbs_ack_o and wbs_err_o are never high in the same cycle.
REQ-027 ch_dat_o, ch_adr_o and ch_we_o hold their latched values throughout BUSY.

Reset
REQ-028 While wbs_rst=0: state IDLE; all outputs 0 (wbs_dat_o, wbs_ack_o, wbs_err_o, wbs_stall_o, ch_cyc_o, ch_stb_o, ch_we_o, ch_adr_o, ch_dat_o); timeout counter 0.
REQ-029 Reset asserted mid-transaction aborts the transaction immediately; no ack or err is issued after release.

Configuration
REQ-030 Macro VIO_TIMEOUT_EN.
REQ-031 With VIO_TIMEOUT_EN defined: the counter clears on entry to BUSY and increments each BUSY cycle; when the count reaches TO_CYC without an ack, the FSM drops the channel strobes and goes to ERR (one-cycle wbs_err_o).
REQ-032 With VIO_TIMEOUT_EN undefined: BUSY waits indefinitely, and no counter logic is generated.

Structure
REQ-033 Shared package versatile_io_pkg holds: FSM state encodings, the default MAP_HI/MAP_LO/TO_CYC constants, and the tobyte/toword helper functions.
REQ-034 One sub-module, versatile_io_timeout (clear, enable, terminal-count output), instantiated only under VIO_TIMEOUT_EN.

Verification
All scenarios use NR_CH=2, CH_BASE ch0=0x1000, ch1=0x2000.
REQ-035 Write to 0x1003 with sel=4'b0100, dat=0x00AB0000 -> ch_cyc_o=2'b01, ch_adr_o=3, ch_dat_o=0xAB, ch_we_o=1; channel ack 2 cycles later -> wbs_ack_o one cycle later, wbs_dat_o=0.
REQ-036 Read from 0x2001; ch1 returns 0x5A with ack -> wbs_dat_o=0x5A5A5A5A together with wbs_ack_o, one cycle after ch_ack_i[1].
REQ-037 Access to 0x7000, or sel=0 at 0x1000 -> wbs_err_o high one cycle; no ch_cyc_o asserted; wbs_ack_o stays 0.
REQ-038 With VIO_TIMEOUT_EN and TO_CYC=8, channel never acks -> ch_cyc_o drops and wbs_err_o pulses after the timeout; without the macro, the FSM stays in BUSY and wbs_stall_o stays 1.
REQ-039 Master drops wbs_cyc_i during BUSY -> ch_cyc_o=0 in the next cycle, state IDLE, no ack or err; a later ch_ack_i is ignored.
REQ-040 wbs_rst pulsed low during BUSY -> all outputs 0 immediately; after release, no ack or err is issued and a new request is accepted normally.
